// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle sequencer: latches inputs, steps the core through the program,
// latches outputs, then paces the next scan to a fixed period.
module vslc_scan_sequencer #(
   parameter int ADDR_W   = 4,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                run,
   input  logic [ADDR_W-1:0]   prog_len,
   input  logic [PERIOD_W-1:0] period,
   input  logic                core_ready,
   output logic [ADDR_W-1:0]   addr,
   output logic                addr_strobe,
   output logic                in_latch,
   output logic                out_latch,
   output logic                scan_cycle_clk,
   output logic                overrun,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH_IN, S_EXEC, S_LATCH_OUT, S_WAIT
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   len_sh, addr_nx;
   logic [PERIOD_W-1:0] per_sh, pcnt, pcnt_nx;
   logic [PERIOD_W:0]   pinc;
   logic                stop, stop_nx, ov_nx, strobe_nx;

   always_comb begin
      state_nx  = state;
      addr_nx   = addr;
      strobe_nx = 1'b0;
      ov_nx     = overrun;
      stop_nx   = stop;
      pcnt_nx   = pcnt;
      // one bit wider than the counter so the period compare never wraps
      pinc      = {1'b0, pcnt} + (PERIOD_W+1)'(1);

      // a run drop seen anywhere mid-scan is remembered until the scan ends
      if (state != S_IDLE && !run) stop_nx = 1'b1;

      case (state)
         S_IDLE: begin
            if (run) begin
               state_nx = S_LATCH_IN;
               ov_nx    = 1'b0;
            end
         end
         S_LATCH_IN: begin
            state_nx  = S_EXEC;
            addr_nx   = '0;
            strobe_nx = 1'b1;
         end
         S_EXEC: begin
            if (core_ready) begin
               if (addr < len_sh) begin
                  addr_nx   = addr + ADDR_W'(1);
                  strobe_nx = 1'b1;
               end else begin
                  state_nx = S_LATCH_OUT;
               end
            end
         end
         S_LATCH_OUT: begin
            if (per_sh != '0 && pinc > {1'b0, per_sh}) ov_nx = 1'b1;
            if (stop_nx)
               state_nx = S_IDLE;
            else if (per_sh == '0 || pinc >= {1'b0, per_sh})
               state_nx = S_LATCH_IN;
            else
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (stop_nx)
               state_nx = S_IDLE;
            else if (pinc >= {1'b0, per_sh})
               state_nx = S_LATCH_IN;
         end
         default: state_nx = S_IDLE;
      endcase

      if (state_nx == S_IDLE || state_nx == S_LATCH_IN) stop_nx = 1'b0;

      if (state_nx == S_LATCH_IN)
         pcnt_nx = '0;
      else if (state != S_IDLE && pcnt != '1)
         pcnt_nx = pcnt + PERIOD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         addr           <= '0;
         pcnt           <= '0;
         len_sh         <= '0;
         per_sh         <= '0;
         stop           <= 1'b0;
         addr_strobe    <= 1'b0;
         in_latch       <= 1'b0;
         out_latch      <= 1'b0;
         scan_cycle_clk <= 1'b0;
         overrun        <= 1'b0;
         busy           <= 1'b0;
      end else if (ena) begin
         state          <= state_nx;
         addr           <= addr_nx;
         pcnt           <= pcnt_nx;
         stop           <= stop_nx;
         overrun        <= ov_nx;
         addr_strobe    <= strobe_nx;
         in_latch       <= (state_nx == S_LATCH_IN);
         out_latch      <= (state_nx == S_LATCH_OUT);
         scan_cycle_clk <= (state_nx == S_LATCH_IN) || (state_nx == S_EXEC);
         busy           <= (state_nx != S_IDLE);
         if (state_nx == S_LATCH_IN) begin
            len_sh <= prog_len;
            per_sh <= period;
         end
      end else begin
         // frozen: pulses drop and are not replayed later
         addr_strobe <= 1'b0;
         in_latch    <= 1'b0;
         out_latch   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Bench for vslc_scan_sequencer: a table of scan configurations plus hand
// sequences; every pulse is matched against a queue of expected events.
module tb_vslc_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, ena, run;
   logic [3:0]  prog_len;
   logic [15:0] period;
   logic        core_ready = 1'b1;
   logic [3:0]  addr;
   logic        addr_strobe, in_latch, out_latch, scan_cycle_clk, overrun, busy;

   vslc_scan_sequencer #(.ADDR_W(4), .PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .prog_len(prog_len),
      .period(period), .core_ready(core_ready), .addr(addr),
      .addr_strobe(addr_strobe), .in_latch(in_latch), .out_latch(out_latch),
      .scan_cycle_clk(scan_cycle_clk), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; int a; int cyc; } ev_t;   // kind 0 in, 1 strobe, 2 out
   typedef struct { int len; int per; int sa; int sn; int scans; int sp; int ov; } row_t;

   ev_t exp_q[$];
   bit  lo_at[int];
   int  cyc = 0;
   int  n_vec = 0, n_err = 0;
   ev_t got, want;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) core_ready = !lo_at.exists(cyc);

   always @(negedge clk) begin
      if (in_latch || addr_strobe || out_latch) begin
         got.kind = in_latch ? 0 : (addr_strobe ? 1 : 2);
         got.a    = addr_strobe ? int'(addr) : 0;
         got.cyc  = cyc;
         n_vec++;
         if (int'(in_latch) + int'(addr_strobe) + int'(out_latch) > 1) begin
            n_err++;
            $display("FAIL pulse_overlap cyc %0d got in/str/out %0b%0b%0b, need one", cyc,
                     in_latch, addr_strobe, out_latch);
         end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL stray_event got kind %0d addr %0d cyc %0d, need none", got.kind, got.a, got.cyc);
         end else begin
            want = exp_q.pop_front();
            if (got.kind != want.kind || got.a != want.a || got.cyc != want.cyc) begin
               n_err++;
               $display("FAIL event got kind %0d addr %0d cyc %0d, need kind %0d addr %0d cyc %0d",
                        got.kind, got.a, got.cyc, want.kind, want.a, want.cyc);
            end
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got %0d need %0d", nm, act, exp);
      end
   endtask

   task automatic push_ev(int kind, int a, int c);
      ev_t e;
      e.kind = kind; e.a = a; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // expected pulses for one scan whose in_latch lands on cycle t
   task automatic push_scan(int t, int len, int sa, int sn);
      push_ev(0, 0, t);
      for (int k = 0; k <= len; k++)
         push_ev(1, k, t + 1 + k + ((sn > 0 && k > sa) ? sn : 0));
      push_ev(2, 0, t + len + 2 + sn);
      for (int j = 0; j < sn; j++) lo_at[t + 1 + sa + j] = 1'b1;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_idle(string nm);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout got %0d pending events busy %0b, need 0 and 0", nm, exp_q.size(), busy);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_addr"}, int'(addr), 0);
      chk({nm, "_strobe"}, int'(addr_strobe), 0);
      chk({nm, "_in_latch"}, int'(in_latch), 0);
      chk({nm, "_out_latch"}, int'(out_latch), 0);
      chk({nm, "_scan_clk"}, int'(scan_cycle_clk), 0);
      chk({nm, "_overrun"}, int'(overrun), 0);
      chk({nm, "_busy"}, int'(busy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b0; run = 1'b0;
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1; ena = 1'b1;
      lo_at.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish, need finish");
      $fatal(1, "watchdog");
   end

   row_t rows[8];
   int   t, tl;

   initial begin
      rst_n = 1'b0; ena = 1'b1; run = 1'b0; prog_len = '0; period = '0;
      rows[0] = '{3, 10, 0, 0, 3, 10, 0};
      rows[1] = '{3,  4, 0, 0, 3,  6, 1};
      rows[2] = '{3,  0, 0, 0, 3,  6, 0};
      rows[3] = '{3,  6, 0, 0, 3,  6, 0};
      rows[4] = '{3,  0, 1, 3, 2,  9, 0};
      rows[5] = '{0,  0, 0, 0, 3,  3, 0};
      rows[6] = '{5,  7, 2, 2, 2, 10, 1};
      rows[7] = '{1,  9, 0, 0, 2,  9, 0};
      repeat (2) @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         do_reset();
         prog_len = 4'(rows[r].len);
         period   = 16'(rows[r].per);
         @(negedge clk);
         run = 1'b1;
         t = cyc + 1;
         tl = t;
         for (int k = 0; k < rows[r].scans; k++) begin
            push_scan(t, rows[r].len, rows[r].sa, rows[r].sn);
            tl = t;
            t += rows[r].sp;
         end
         wait_cyc(tl + 1);
         run = 1'b0;
         wait_idle($sformatf("row%0d", r));
         chk($sformatf("row%0d_overrun", r), int'(overrun), rows[r].ov);
         chk($sformatf("row%0d_scan_clk", r), int'(scan_cycle_clk), 0);
      end

      // ena held low for two cycles while addr=1 is being executed
      do_reset();
      prog_len = 4'd3; period = 16'd0;
      @(negedge clk);
      run = 1'b1;
      t = cyc + 1;
      push_ev(0, 0, t);     push_ev(1, 0, t + 1); push_ev(1, 1, t + 2);
      push_ev(1, 2, t + 5); push_ev(1, 3, t + 6); push_ev(2, 0, t + 7);
      wait_cyc(t + 1);
      run = 1'b0;
      wait_cyc(t + 2);
      ena = 1'b0;
      @(negedge clk);
      chk("freeze_addr_a", int'(addr), 1);
      chk("freeze_strobe_a", int'(addr_strobe), 0);
      chk("freeze_busy", int'(busy), 1);
      @(negedge clk);
      chk("freeze_addr_b", int'(addr), 1);
      chk("freeze_scan_clk", int'(scan_cycle_clk), 1);
      ena = 1'b1;
      wait_idle("freeze");

      // overrun scan, then a long-period scan into WAIT, reset while waiting
      do_reset();
      prog_len = 4'd3; period = 16'd4;
      @(negedge clk);
      run = 1'b1;
      t = cyc + 1;
      push_scan(t, 3, 0, 0);
      push_scan(t + 6, 3, 0, 0);
      wait_cyc(t);
      period = 16'd20;
      wait_cyc(t + 12);
      chk("wait_overrun", int'(overrun), 1);
      chk("wait_busy", int'(busy), 1);
      chk("wait_scan_clk", int'(scan_cycle_clk), 0);
      wait_cyc(t + 13);
      rst_n = 1'b0; run = 1'b0;
      @(negedge clk);
      chk_zero("wait_reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("wait_reset_idle", int'(busy), 0);
      chk("wait_reset_pending", exp_q.size(), 0);

      // reset in the middle of EXEC, then a clean restart
      do_reset();
      prog_len = 4'd3; period = 16'd0;
      @(negedge clk);
      run = 1'b1;
      t = cyc + 1;
      push_ev(0, 0, t); push_ev(1, 0, t + 1); push_ev(1, 1, t + 2);
      wait_cyc(t + 2);
      rst_n = 1'b0; run = 1'b0;
      @(negedge clk);
      chk_zero("exec_reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("exec_reset_idle", int'(busy), 0);
      run = 1'b1;
      t = cyc + 1;
      push_scan(t, 3, 0, 0);
      wait_cyc(t + 1);
      run = 1'b0;
      wait_idle("restart");
      chk("restart_overrun", int'(overrun), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
